// File: rtl/module_bus_interconect_param.sv
// Registered, parametrised bus interconnect between one CPU data port and N_SLV
// peripherals. Each request is decoded against per-slave base/mask windows and
// then steered to the winning slave. Slaves may insert wait states through
// ready_i. Unmapped requests and slaves that never answer return an error response.
module module_bus_interconect_param #(
    parameter int                      N_SLV     = 8,
    parameter int                      ADDR_W    = 32,
    parameter int                      DATA_W    = 32,
    // slot 0 RAM, 1 teclado, 2 LEDs, 3 7-seg, 4 timer, 5 RGB, 6 UART, 7 SPI buffer
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE  = {32'h0000_2200, 32'h0000_2018,
                                                    32'h0000_2014, 32'h0000_2010,
                                                    32'h0000_200C, 32'h0000_2008,
                                                    32'h0000_2004, 32'h0000_1000},
    // SPI buffer: 4 KiB page at 0x2000 qualified by address bit 0x200
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK  = {32'hFFFF_F200, 32'hFFFF_FFF8,
                                                    32'hFFFF_FFFC, 32'hFFFF_FFFC,
                                                    32'hFFFF_FFFC, 32'hFFFF_FFFC,
                                                    32'hFFFF_FFFC, 32'hFFFF_FC00},
    parameter int                      TIMEOUT   = 16,
    parameter logic [DATA_W-1:0]       ERR_RDATA = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [DATA_W-1:0]       wdata_i,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    ack_o,
    output logic                    err_o,
    output logic                    busy_o,
    output logic [N_SLV-1:0]        sel_o,
    output logic [N_SLV-1:0]        we_o,
    output logic [ADDR_W-1:0]       addr_o,
    output logic [DATA_W-1:0]       wdata_o,
    input  logic [N_SLV*DATA_W-1:0] rdata_i,
    input  logic [N_SLV-1:0]        ready_i,
    output logic [7:0]              err_cnt_o
);

    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t             state_q,   state_d;
    logic [ADDR_W-1:0]  addr_q,    addr_d;
    logic [DATA_W-1:0]  wdata_q,   wdata_d;
    logic               we_q,      we_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic               err_q,     err_d;
    logic [DATA_W-1:0]  rdata_q,   rdata_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic               hit_any;
    logic [IDX_W-1:0]   hit_idx;
    logic [7:0]         err_cnt_inc;

    // Address decode: scan from the top so the lowest matching slot wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        hit_any = 1'b0;
        hit_idx = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if ((addr_i & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // Next-state and datapath latch update for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        idx_d     = idx_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    we_d    = we_i;
                    idx_d   = hit_idx;
                    cnt_d   = CNT_W'(1);
                    if (hit_any) begin
                        state_d = ST_ACCESS;
                        err_d   = 1'b0;
                    end else begin
                        state_d   = ST_RESP;
                        err_d     = 1'b1;
                        rdata_d   = ERR_RDATA;
                        err_cnt_d = err_cnt_inc;
                    end
                end
            end
            ST_ACCESS: begin
                if (ready_i[idx_q]) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : rdata_i[idx_q*DATA_W +: DATA_W];
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d   = ST_RESP;
                    err_d     = 1'b1;
                    rdata_d   = ERR_RDATA;
                    err_cnt_d = err_cnt_inc;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latch registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: the address/data latches are reset too, so addr_o/wdata_o/rdata_o read 0 after reset.
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Slave-side strobes come straight from the state, so a reset drops them immediately.
    always_comb begin
        sel_o = '0;
        for (int k = 0; k < N_SLV; k++) begin
            sel_o[k] = (state_q == ST_ACCESS) && (idx_q == IDX_W'(k));
        end
    end

    assign we_o      = sel_o & {N_SLV{we_q}};
    assign ack_o     = (state_q == ST_RESP);
    assign err_o     = (state_q == ST_RESP) && err_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign rdata_o   = rdata_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_module_bus_interconect_param.sv
// Scoreboard bench for module_bus_interconect_param: the driver predicts every
// response from the address map and slave wait settings, and a monitor compares
// each ack (and each slave-side strobe) against that prediction.
module tb_module_bus_interconect_param;

    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int TO  = 16;
    localparam int NEVER = 255;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req = 1'b0;
    logic            we = 1'b0;
    logic [31:0]     addr = '0;
    logic [31:0]     wdata = '0;
    logic [31:0]     rdata_o;
    logic            ack_o, err_o, busy_o;
    logic [N-1:0]    sel_o, we_o;
    logic [31:0]     addr_o, wdata_o;
    logic [N*DW-1:0] rdata_s = '0;
    logic [N-1:0]    ready_s = '0;
    logic [7:0]      err_cnt_o;

    module_bus_interconect_param dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .we_i      (we),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .rdata_o   (rdata_o),
        .ack_o     (ack_o),
        .err_o     (err_o),
        .busy_o    (busy_o),
        .sel_o     (sel_o),
        .we_o      (we_o),
        .addr_o    (addr_o),
        .wdata_o   (wdata_o),
        .rdata_i   (rdata_s),
        .ready_i   (ready_s),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk = ~clk;

    // System address map as documented for the default parameters.
    logic [31:0] base_tb [N] = '{32'h1000, 32'h2004, 32'h2008, 32'h200C,
                                 32'h2010, 32'h2014, 32'h2018, 32'h2200};
    logic [31:0] mask_tb [N] = '{32'hFFFF_FC00, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
                                 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_F200};

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  ecnt;
        int          ack_cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [7:0]  exp_ecnt = '0;
    int          wait_cfg [N] = '{default: 0};
    int          acc [N] = '{default: 0};
    logic        cur_vld = 1'b0;
    int          cur_idx = -1;
    logic        cur_we = 1'b0;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int k = 0; k < N; k++) begin
            if ((a & mask_tb[k]) == base_tb[k]) return k;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Slave models: the selected slave answers after wait_cfg cycles; others toggle ready randomly.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (sel_o[k]) begin
                acc[k]     <= acc[k] + 1;
                ready_s[k] <= (wait_cfg[k] != NEVER) && (acc[k] + 1 > wait_cfg[k]);
            end else begin
                acc[k]     <= 0;
                ready_s[k] <= 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pop one expectation per ack, and check slave-side strobes while selected.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ack_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 64'(ack_o), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("ack_err", 64'(err_o), 64'(mon_e.err));
                    check("ack_rdata", 64'(rdata_o), 64'(mon_e.rdata));
                    check("ack_err_cnt", 64'(err_cnt_o), 64'(mon_e.ecnt));
                    check("ack_cycle", 64'(cyc), 64'(mon_e.ack_cyc));
                end
            end
            if (sel_o != '0) begin
                if (!cur_vld || cur_idx < 0) begin
                    check("unexpected_sel", 64'(sel_o), 64'd0);
                end else begin
                    check("sel_onehot", 64'(sel_o), 64'(N'(1) << cur_idx));
                    check("we_onehot", 64'(we_o), cur_we ? 64'(N'(1) << cur_idx) : 64'd0);
                    check("addr_o", 64'(addr_o), 64'(cur_addr));
                    check("wdata_o", 64'(wdata_o), 64'(cur_wdata));
                end
            end
        end
    end

    // Drive one request at the current negedge (DUT idle) and record its expected response.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int wt, input logic [31:0] sdata);
        int   idx;
        exp_t e;
        logic err;
        idx = decode(a);
        for (int k = 0; k < N; k++) rdata_s[k*DW +: DW] = $urandom;
        if (idx >= 0) begin
            rdata_s[idx*DW +: DW] = sdata;
            wait_cfg[idx]         = wt;
        end
        err = (idx < 0) || (wt == NEVER);
        if (err && exp_ecnt != 8'hFF) exp_ecnt++;
        e.err     = err;
        e.rdata   = err ? ERR_WORD : (w ? 32'h0 : sdata);
        e.ecnt    = exp_ecnt;
        e.ack_cyc = cyc + 1 + ((idx < 0) ? 0 : ((wt == NEVER) ? TO : wt + 1));
        sb_q.push_back(e);
        cur_vld   = 1'b1;
        cur_idx   = idx;
        cur_we    = w;
        cur_addr  = a;
        cur_wdata = d;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    // Wait (bounded) for the DUT to return idle, optionally keeping req_i high with junk meanwhile.
    task automatic finish_txn(input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < 200) begin
            if (hold) begin
                req   = 1'b1;
                addr  = $urandom;
                wdata = $urandom;
                we    = 1'($urandom_range(0, 1));
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        check("return_idle", 64'(busy_o), 64'd0);
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int wt, input logic [31:0] sdata, input bit hold);
        issue(w, a, d, wt, sdata);
        finish_txn(hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int          r;
        logic [31:0] a;
        int          wt;
        #3;
        check("rst_ack", 64'(ack_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_sel", 64'(sel_o), 64'd0);
        check("rst_we", 64'(we_o), 64'd0);
        check("rst_rdata", 64'(rdata_o), 64'd0);
        check("rst_addr", 64'(addr_o), 64'd0);
        check("rst_wdata", 64'(wdata_o), 64'd0);
        check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the system map.
        txn(1'b0, 32'h2004, 32'h0,  0,     32'd10,   1'b0);
        txn(1'b1, 32'h1010, 32'h55, 0,     32'h1234, 1'b0);
        txn(1'b0, 32'h3000, 32'h0,  0,     32'h0,    1'b0);
        txn(1'b0, 32'h2010, 32'h0,  NEVER, 32'h0,    1'b0);
        txn(1'b0, 32'h2018, 32'h0,  3,     32'h77,   1'b1);
        check("err_cnt_directed", 64'(err_cnt_o), 64'd2);

        // Reset in the middle of a stalled access.
        issue(1'b1, 32'h2010, 32'hCAFE, NEVER, 32'h0);
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("sel_before_reset", 64'(sel_o), 64'h10);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sel", 64'(sel_o), 64'd0);
        check("mid_rst_we", 64'(we_o), 64'd0);
        check("mid_rst_ack", 64'(ack_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_err_cnt", 64'(err_cnt_o), 64'd0);
        void'(sb_q.pop_back());
        exp_ecnt = '0;
        cur_vld  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 32'h2008, 32'h0, 1, 32'hABCD, 1'b0);

        // Randomized traffic over mapped windows and arbitrary addresses.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < N) a = base_tb[r] | ($urandom & ~mask_tb[r]);
            else       a = $urandom;
            wt = ($urandom_range(0, 15) == 0) ? NEVER : $urandom_range(0, 4);
            txn(1'($urandom_range(0, 1)), a, $urandom, wt, $urandom, 1'($urandom_range(0, 1)));
        end

        // Drive the error counter into saturation.
        for (int i = 0; i < 260; i++) begin
            txn(1'b0, 32'h3000, 32'h0, 0, 32'h0, 1'b0);
        end
        check("err_cnt_saturated", 64'(err_cnt_o), 64'd255);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
